branch_cc_sequencer: RTL and testbench
======================================

# branch_cc_sequencer

Control FSM that sequences the SLC-3 `NZP_BEN_block` for each issued instruction. It pulses `LD_CC` when a condition-code-setting result is on the bus. For BR it pulses `LD_BEN`, then evaluates `BEN` and, when the branch is taken, loads PC through the adder path. It sits beside the ISDU, between the instruction-issue handshake and the NZP/BEN register plus PC load controls, and keeps saturating branch statistics.

## Interface
Parameters:
- `CNT_W`, 16: width of the statistics counters.
- `TIMEOUT`, 15: maximum number of cycles spent in `S_WAIT_RES` before aborting.

Ports:
- `Clk`  in  1: system clock, rising edge.
- `Reset`  in  1: asynchronous, active-low reset.
- `issue_valid`  in  1: an instruction is offered.
- `issue_ready`  out  1: the sequencer accepts an instruction.
- `opcode`  in  4: IR[15:12] of the offered instruction.
- `result_valid`  in  1: the datapath result is on `bus` this cycle.
- `BEN`  in  1: registered BEN from `NZP_BEN_block`.
- `LD_CC`  out  1: load enable for the NZP register.
- `LD_BEN`  out  1: load enable for the BEN register.
- `LD_PC`  out  1: PC load enable.
- `PCMUX_sel`  out  2: PC mux select.
- `done`  out  1: one-cycle pulse when the instruction retires.
- `err`  out  1: one-cycle pulse on result timeout; coincides with `done`.
- `stats_clr`  in  1: synchronous clear of both counters.
- `branch_count`  out  CNT_W: number of BRs evaluated.
- `taken_count`  out  CNT_W: number of BRs taken.

## Operation
- States: `S_IDLE`, `S_WAIT_RES`, `S_BEN_LD`, `S_BEN_EVAL`, `S_BR_TAKE`, `S_DONE`.
- `issue_ready` = (state == `S_IDLE`). An instruction is accepted when `issue_valid && issue_ready`.
- Transitions out of `S_IDLE` on accept:
  - ADD (0001), AND (0101), NOT (1001), LDR (0110): go to `S_WAIT_RES`; the wait counter clears.
  - BR (0000): go to `S_BEN_LD`.
  - Any other opcode: go to `S_DONE`.
- `S_WAIT_RES`:
  - `LD_CC` = `result_valid` (Mealy output).
  - On `result_valid`: go to `S_DONE`.
  - Otherwise the wait counter increments. When it reaches `TIMEOUT`, go to `S_DONE` with `err` flagged and no `LD_CC`.
- `S_BEN_LD`: `LD_BEN` = 1; next state `S_BEN_EVAL`.
- `S_BEN_EVAL`:
  - Sample `BEN`; `branch_count` += 1.
  - `BEN` = 1: go to `S_BR_TAKE`, `taken_count` += 1.
  - `BEN` = 0: go to `S_DONE`.
- `S_BR_TAKE`: `LD_PC` = 1, `PCMUX_sel` = `PCMUX_ADDER`; next state `S_DONE`.
- `S_DONE`: `done` = 1 (`err` = 1 if the timeout flag is set); next state `S_IDLE`.
- In all states other than `S_BR_TAKE`, `PCMUX_sel` = `PCMUX_INC`. `LD_CC`, `LD_BEN`, `LD_PC` and `done` default to 0.
- Counters saturate at all-ones and do not wrap.
- `stats_clr` takes priority over a simultaneous increment; the counter reads 0 after the edge.
- `LD_CC` and `LD_BEN` are never asserted in the same cycle.
- `issue_valid` is ignored outside `S_IDLE`; no instruction is queued.

## Timing
- Reset (`Reset` = 0, asynchronous):
  - State returns to `S_IDLE`; both counters, the wait counter and the timeout flag clear.
  - Outputs: `issue_ready` = 1; all other outputs 0, `PCMUX_sel` = `PCMUX_INC`.
- Reset mid-instruction aborts immediately. No `done` is pulsed, and no pending `LD_*` strobe is issued.
- Latency from the accept edge to the `done` cycle:
  - Non-CC, non-BR opcode: 1 cycle.
  - CC-setting op: k+1 cycles, where `result_valid` arrives k ≥ 1 cycles after accept.
  - BR not taken: 3 cycles.
  - BR taken: 4 cycles.
- Back-to-back issue: the next accept is possible in the cycle after `done`.
- `BEN` is sampled one cycle after the `LD_BEN` cycle, which covers the one-edge register delay of `NZP_BEN_block`.

## Structure
- Package `slc3_ctrl_pkg` holds:
  - opcode constants `OP_BR`, `OP_ADD`, `OP_AND`, `OP_NOT`, `OP_LDR`;
  - the `branch_state_t` enum;
  - `PCMUX_INC` = 2'b00 and `PCMUX_ADDER` = 2'b10.
- One sub-module, `sat_counter` (parameter `W`; inputs `inc`, `clr`; output `q`), instantiated twice for the statistics counters.
- The FSM, wait counter and output decode live in the top module.

## Test plan
- Reset asserted mid-`S_WAIT_RES` -> next cycle `S_IDLE`, `issue_ready` = 1, no `done`, counters 0.
- ADD issued, `result_valid` held low for 2 cycles then high -> `LD_CC` = 1 exactly in the `result_valid` cycle; `done` 1 cycle later; `err` = 0.
- BR with `IR11` = 001 after `bus` = 16'h0001 was loaded into CC -> `LD_BEN` in cycle 1, `LD_PC` = 1 with `PCMUX_sel` = 2'b10 in cycle 3, `done` in cycle 4; `taken_count` = 1, `branch_count` = 1.
- BR with `IR11` = 100 after `bus` = 16'h0001 -> no `LD_PC`, `done` in cycle 3; `branch_count` increments, `taken_count` is unchanged.
- LDR with `result_valid` never asserted and `TIMEOUT` = 15 -> `done` and `err` pulse together; `LD_CC` is never asserted.
- Counters preloaded to all-ones via forced BR stream (`CNT_W` = 4) -> they hold at 4'hF. `stats_clr` in the same cycle as an increment -> 0.

Source files
------------

// File: rtl/slc3_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// slc3_ctrl_pkg
// Shared control definitions for the SLC-3 branch / condition-code sequencer:
//   - opcode constants (IR[15:12]) for the instructions the sequencer decodes
//   - PC mux select encodings
//   - branch_state_t, the sequencer FSM state type
//   - is_cc_op(), which picks out the opcodes whose result loads NZP
// -----------------------------------------------------------------------------
package slc3_ctrl_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDR = 4'b0110;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RES = 3'd1,
        S_BEN_LD   = 3'd2,
        S_BEN_EVAL = 3'd3,
        S_BR_TAKE  = 3'd4,
        S_DONE     = 3'd5
    } branch_state_t;

    // True for the opcodes whose datapath result must be captured into NZP.
    function automatic logic is_cc_op(input logic [3:0] op);
        logic hit;
        case (op)
            OP_ADD:  hit = 1'b1;
            OP_AND:  hit = 1'b1;
            OP_NOT:  hit = 1'b1;
            OP_LDR:  hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   in  1 : clock, rising edge
//   rst_n in  1 : asynchronous active-low reset (counter -> 0)
//   inc   in  1 : add one this cycle (ignored once saturated)
//   clr   in  1 : synchronous clear; wins over a simultaneous inc
//   q     out W : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: clear first, then saturating increment, else hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = CNT_ZERO;
        end else if (inc && (q_q != CNT_MAX)) begin
            q_d = q_q + CNT_ONE;
        end else begin
            q_d = q_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= CNT_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/branch_cc_sequencer.sv
// -----------------------------------------------------------------------------
// branch_cc_sequencer
// Control FSM beside the ISDU that drives the NZP/BEN block and the PC load
// for each issued instruction, and keeps saturating branch statistics.
//   - CC-setting ops (ADD/AND/NOT/LDR) wait for result_valid and strobe LD_CC
//     in that same cycle; a result that never arrives is abandoned after
//     TIMEOUT cycles and retired with err.
//   - BR strobes LD_BEN, samples BEN the following cycle, and on taken loads
//     PC through the adder path.
//   - Every other opcode retires one cycle after accept.
// Ports:
//   Clk, Reset          : clock (rising edge), async active-low reset
//   issue_valid/_ready  : instruction issue handshake (ready only in S_IDLE)
//   opcode [3:0]        : IR[15:12] of the offered instruction
//   result_valid        : datapath result is on the bus this cycle
//   BEN                 : registered branch-enable from NZP_BEN_block
//   LD_CC, LD_BEN       : NZP / BEN register load enables
//   LD_PC, PCMUX_sel    : PC load enable and PC mux select
//   done, err           : retire pulse, timeout pulse (coincides with done)
//   stats_clr           : synchronous clear of both statistics counters
//   branch_count        : BRs evaluated (saturating)
//   taken_count         : BRs taken (saturating)
// -----------------------------------------------------------------------------
module branch_cc_sequencer
    import slc3_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       opcode,
    input  logic             result_valid,
    input  logic             BEN,
    output logic             LD_CC,
    output logic             LD_BEN,
    output logic             LD_PC,
    output logic [1:0]       PCMUX_sel,
    output logic             done,
    output logic             err,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    // Wide enough to hold the value TIMEOUT itself.
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO  = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

    branch_state_t     state_q;
    branch_state_t     state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic [WAIT_W-1:0] wait_inc_s;
    logic              timeout_q;
    logic              timeout_d;
    logic              br_inc_s;
    logic              tk_inc_s;

    assign wait_inc_s = wait_cnt_q + WAIT_ONE;

    // Next-state, wait-counter and output decode.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        issue_ready = 1'b0;
        LD_CC       = 1'b0;
        LD_BEN      = 1'b0;
        LD_PC       = 1'b0;
        PCMUX_sel   = PCMUX_INC;
        done        = 1'b0;
        err         = 1'b0;
        br_inc_s    = 1'b0;
        tk_inc_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    wait_cnt_d = WAIT_ZERO;
                    timeout_d  = 1'b0;
                    if (is_cc_op(opcode)) begin
                        state_d = S_WAIT_RES;
                    end else if (opcode == OP_BR) begin
                        state_d = S_BEN_LD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WAIT_RES: begin
                // A result arriving in the last allowed cycle still counts.
                if (result_valid) begin
                    LD_CC   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_inc_s;
                    if (wait_inc_s == WAIT_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_WAIT_RES;
                    end
                end
            end

            S_BEN_LD: begin
                LD_BEN  = 1'b1;
                state_d = S_BEN_EVAL;
            end

            S_BEN_EVAL: begin
                // BEN now reflects the value latched by the LD_BEN strobe.
                br_inc_s = 1'b1;
                if (BEN) begin
                    tk_inc_s = 1'b1;
                    state_d  = S_BR_TAKE;
                end else begin
                    state_d = S_DONE;
                end
            end

            S_BR_TAKE: begin
                LD_PC     = 1'b1;
                PCMUX_sel = PCMUX_ADDER;
                state_d   = S_DONE;
            end

            S_DONE: begin
                done      = 1'b1;
                err       = timeout_q;
                timeout_d = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                timeout_d = 1'b0;
            end
        endcase
    end

    // FSM state, wait counter and timeout flag registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= WAIT_ZERO;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .inc   (br_inc_s),
        .clr   (stats_clr),
        .q     (branch_count)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .inc   (tk_inc_s),
        .clr   (stats_clr),
        .q     (taken_count)
    );

endmodule

// File: tb/tb_branch_cc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_branch_cc_sequencer
// Table of directed instructions, hand-written saturation / clear / reset
// sequences, then random instructions checked against a transaction-level
// model (latency, strobe cycles, err, counters, NZP contents).
// A small NZP/BEN register model sits around the DUT to produce BEN.
// -----------------------------------------------------------------------------
module tb_branch_cc_sequencer;
    import slc3_ctrl_pkg::*;

    localparam int CW = 4;
    localparam int TO = 15;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid;
    logic          issue_ready;
    logic [3:0]    opcode;
    logic          result_valid;
    logic          ben;
    logic          ld_cc, ld_ben, ld_pc;
    logic [1:0]    pcmux;
    logic          done, err;
    logic          stats_clr;
    logic [CW-1:0] branch_count, taken_count;

    logic [15:0]   bus;
    logic [2:0]    ir11;
    logic [2:0]    nzp_env = 3'b000;
    logic          ben_env = 1'b0;

    int tests = 0;
    int fails = 0;

    // model state
    int         bc_m = 0;
    int         tc_m = 0;
    logic [2:0] nzp_m = 3'b000;

    always #5 clk = ~clk;

    branch_cc_sequencer #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .Clk          (clk),
        .Reset        (rst_n),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .opcode       (opcode),
        .result_valid (result_valid),
        .BEN          (ben),
        .LD_CC        (ld_cc),
        .LD_BEN       (ld_ben),
        .LD_PC        (ld_pc),
        .PCMUX_sel    (pcmux),
        .done         (done),
        .err          (err),
        .stats_clr    (stats_clr),
        .branch_count (branch_count),
        .taken_count  (taken_count)
    );

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if (v[15])          return 3'b100;
        else if (v == 16'h0) return 3'b010;
        else                return 3'b001;
    endfunction

    // environment: NZP and BEN registers of NZP_BEN_block
    always @(posedge clk) begin
        if (ld_cc)  nzp_env <= nzp_of(bus);
        if (ld_ben) ben_env <= |(ir11 & nzp_env);
    end
    assign ben = ben_env;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_cc(input logic [3:0] op);
        return (op == 4'b0001) || (op == 4'b0101) || (op == 4'b1001) || (op == 4'b0110);
    endfunction

    // Issue one instruction and observe it until done (bounded).
    task automatic run_instr(input logic [3:0] op, input logic [2:0] irv, input logic [15:0] bv,
                             input int k, input int clr_c,
                             output int lat, output int ldcc_c, output int ldcc_n,
                             output int ldben_c, output int ldpc_c, output int errv,
                             output int viol, output int rdy0);
        lat = -1; ldcc_c = -1; ldcc_n = 0; ldben_c = -1; ldpc_c = -1; errv = 0; viol = 0;
        @(posedge clk); #1;
        opcode = op; ir11 = irv; bus = bv; issue_valid = 1'b1;
        result_valid = 1'b0; stats_clr = (clr_c == 0);
        @(negedge clk);
        rdy0 = int'(issue_ready);
        if (ld_cc || ld_ben || ld_pc || done || err || pcmux != 2'b00) viol++;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            opcode       = 4'($urandom_range(0, 15));   // must be ignored
            issue_valid  = 1'b1;
            result_valid = (k > 0) && (c == k);
            stats_clr    = (clr_c == c);
            @(negedge clk);
            if (issue_ready) viol++;
            if (ld_cc) begin ldcc_n++; ldcc_c = c; end
            if (ld_ben) ldben_c = c;
            if (ld_pc) ldpc_c = c;
            if (ld_cc && ld_ben) viol++;
            if (pcmux != (ld_pc ? 2'b10 : 2'b00)) viol++;
            if (err && !done) viol++;
            if (done) begin
                lat  = c;
                errv = int'(err);
                break;
            end
        end
        issue_valid = 1'b0; result_valid = 1'b0; stats_clr = 1'b0;
    endtask

    // Run one instruction, compare against expectations, advance the model.
    task automatic apply(input string tag, input logic [3:0] op, input logic [2:0] irv,
                         input logic [15:0] bv, input int k, input int clr_c,
                         input int e_lat, input int e_ldcc, input int e_ldben,
                         input int e_ldpc, input int e_err);
        int lat, ldcc_c, ldcc_n, ldben_c, ldpc_c, errv, viol, rdy0;
        bit is_br, taken, clr_hit;
        run_instr(op, irv, bv, k, clr_c, lat, ldcc_c, ldcc_n, ldben_c, ldpc_c, errv, viol, rdy0);
        chk({tag, ".ready"}, rdy0, 1);
        chk({tag, ".latency"}, lat, e_lat);
        chk({tag, ".ldcc_cycle"}, ldcc_c, e_ldcc);
        chk({tag, ".ldcc_pulses"}, ldcc_n, (e_ldcc >= 0) ? 1 : 0);
        chk({tag, ".ldben_cycle"}, ldben_c, e_ldben);
        chk({tag, ".ldpc_cycle"}, ldpc_c, e_ldpc);
        chk({tag, ".err"}, errv, e_err);
        chk({tag, ".violations"}, viol, 0);
        // model update
        is_br   = (op == OP_BR);
        taken   = is_br && (|(irv & nzp_m));
        clr_hit = (clr_c >= 0);
        if (clr_hit && clr_c < 2) begin bc_m = 0; tc_m = 0; end
        if (is_br && !(clr_hit && clr_c >= 2)) begin
            if (bc_m < CMAX) bc_m++;
            if (taken && tc_m < CMAX) tc_m++;
        end
        if (clr_hit && clr_c >= 2) begin bc_m = 0; tc_m = 0; end
        if (is_cc(op) && k >= 1 && k <= TO) nzp_m = nzp_of(bv);
        chk({tag, ".branch_count"}, int'(branch_count), bc_m);
        chk({tag, ".taken_count"}, int'(taken_count), tc_m);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  ir;
        logic [15:0] bv;
        int          k;
        int          clr_c;
        int          lat;
        int          ldcc;
        int          ldben;
        int          ldpc;
        int          err;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int ok;
        tbl[0]  = '{4'b0001, 3'b000, 16'h0001,  3, -1,  4,  3, -1, -1, 0}; // ADD, P
        tbl[1]  = '{4'b0000, 3'b001, 16'h0000,  0, -1,  4, -1,  1,  3, 0}; // BRp taken
        tbl[2]  = '{4'b0000, 3'b100, 16'h0000,  0, -1,  3, -1,  1, -1, 0}; // BRn not taken
        tbl[3]  = '{4'b0101, 3'b000, 16'h8000,  1, -1,  2,  1, -1, -1, 0}; // AND, N
        tbl[4]  = '{4'b0000, 3'b100, 16'h0000,  0, -1,  4, -1,  1,  3, 0}; // BRn taken
        tbl[5]  = '{4'b1001, 3'b000, 16'h0000,  2, -1,  3,  2, -1, -1, 0}; // NOT, Z
        tbl[6]  = '{4'b0000, 3'b011, 16'h0000,  0, -1,  4, -1,  1,  3, 0}; // BRzp taken
        tbl[7]  = '{4'b0000, 3'b101, 16'h0000,  0, -1,  3, -1,  1, -1, 0}; // BRnp not taken
        tbl[8]  = '{4'b0110, 3'b000, 16'h0001,  0, -1, 16, -1, -1, -1, 1}; // LDR timeout
        tbl[9]  = '{4'b1100, 3'b000, 16'h0000,  0, -1,  1, -1, -1, -1, 0}; // JMP
        tbl[10] = '{4'b0000, 3'b000, 16'h0000,  0, -1,  3, -1,  1, -1, 0}; // BR never
        tbl[11] = '{4'b0110, 3'b000, 16'h0001, 15, -1, 16, 15, -1, -1, 0}; // LDR last-cycle result
        tbl[12] = '{4'b0001, 3'b000, 16'h0001,  1,  0,  2,  1, -1, -1, 0}; // ADD + stats_clr
        tbl[13] = '{4'b0000, 3'b111, 16'h0000,  0,  1,  4, -1,  1,  3, 0}; // clr before eval

        rst_n = 1'b0; issue_valid = 1'b0; opcode = 4'h0; result_valid = 1'b0;
        stats_clr = 1'b0; bus = 16'h0; ir11 = 3'b000;
        #12;
        chk("reset.issue_ready", int'(issue_ready), 1);
        chk("reset.strobes", int'({ld_cc, ld_ben, ld_pc, done, err}), 0);
        chk("reset.pcmux", int'(pcmux), 0);
        chk("reset.counters", int'({branch_count, taken_count}), 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            apply($sformatf("vec%0d", i), tbl[i].op, tbl[i].ir, tbl[i].bv, tbl[i].k, tbl[i].clr_c,
                  tbl[i].lat, tbl[i].ldcc, tbl[i].ldben, tbl[i].ldpc, tbl[i].err);

        // saturate with taken BRs (NZP holds P), back to back
        for (int i = 0; i < 16; i++)
            apply("sat", OP_BR, 3'b001, 16'h0, 0, -1, 4, -1, 1, 3, 0);
        chk("sat.branch_hold", int'(branch_count), 15);
        chk("sat.taken_hold", int'(taken_count), 15);
        // clear in the very cycle the counters would increment
        apply("clr_eval", OP_BR, 3'b001, 16'h0, 0, 2, 4, -1, 1, 3, 0);
        chk("clr_eval.branch_zero", int'(branch_count), 0);
        chk("clr_eval.taken_zero", int'(taken_count), 0);
        apply("post_clr", OP_BR, 3'b001, 16'h0, 0, -1, 4, -1, 1, 3, 0);

        // reset while waiting for a result
        @(posedge clk); #1;
        opcode = OP_ADD; bus = 16'h8000; issue_valid = 1'b1;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid.busy", int'(issue_ready), 0);
        #2 rst_n = 1'b0; result_valid = 1'b1;
        #1;
        chk("rst_mid.issue_ready", int'(issue_ready), 1);
        chk("rst_mid.strobes", int'({ld_cc, ld_ben, ld_pc, done, err}), 0);
        chk("rst_mid.counters", int'({branch_count, taken_count}), 0);
        @(negedge clk); rst_n = 1'b1; result_valid = 1'b0;
        bc_m = 0; tc_m = 0;
        ok = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (!issue_ready || done || err || ld_cc) ok = 0;
        end
        chk("rst_mid.idle_after", ok, 1);
        // the NZP register never saw the aborted result
        apply("rst_mid.br", OP_BR, 3'b001, 16'h0, 0, -1,
              (|(3'b001 & nzp_m)) ? 4 : 3, -1, 1, (|(3'b001 & nzp_m)) ? 3 : -1, 0);

        // random instructions against the transaction model
        for (int n = 0; n < 120; n++) begin
            logic [3:0]  op;
            logic [2:0]  irv;
            logic [15:0] bv;
            int k, clr_c, e_lat, e_ldcc, e_ldben, e_ldpc, e_err, sel;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    op = OP_BR;
                2:       op = OP_ADD;
                3:       op = OP_AND;
                4:       op = OP_NOT;
                5:       op = OP_LDR;
                default: op = 4'($urandom_range(0, 15));
            endcase
            irv = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       bv = 16'h0000;
                1:       bv = 16'h8000 | 16'($urandom_range(0, 32767));
                default: bv = 16'($urandom_range(1, 32767));
            endcase
            k = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO + 1));
            e_ldcc = -1; e_ldben = -1; e_ldpc = -1; e_err = 0;
            if (is_cc(op)) begin
                if (k >= 1 && k <= TO) begin e_lat = k + 1; e_ldcc = k; end
                else begin e_lat = TO + 1; e_err = 1; end
            end else if (op == OP_BR) begin
                e_ldben = 1;
                if (|(irv & nzp_m)) begin e_lat = 4; e_ldpc = 3; end
                else e_lat = 3;
            end else begin
                e_lat = 1;
            end
            clr_c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, e_lat - 1)) : -1;
            apply($sformatf("rnd%0d", n), op, irv, bv, k, clr_c, e_lat, e_ldcc, e_ldben, e_ldpc, e_err);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
